// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART bridge arbiter: FSM states,
// bridge command encodings and bus widths.
package uart_bridge_pkg;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 32;

    localparam logic [2:0] WR_SEL_WRITE = 3'b100;
    localparam logic [2:0] WR_SEL_READ  = 3'b010;
    localparam logic [2:0] WR_SEL_NONE  = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } arb_state_e;

endpackage

// File: rtl/uart_bridge_arb_if.sv
// Requester and bridge signals of the arbiter. The slave modport is the
// arbiter's view; the master modport is the requesters/bridge side.
interface uart_bridge_arb_if
    import uart_bridge_pkg::*;
#(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_wr;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        req_grant;
    logic [NREQ-1:0]        req_done;
    logic                   req_err;
    logic [DATA_W-1:0]      req_rdata;
    logic                   busy;
    logic [2:0]             UnUb_wr_sel;
    logic [ADDR_W-1:0]      UnUb_initAddr;
    logic                   UnUb_initAddrEn;
    logic [DATA_W-1:0]      UcUb_data_out;
    logic                   UbUc_data_out_en;
    logic                   br_wr_done;
    logic                   br_rd_valid;
    logic [DATA_W-1:0]      br_rdata;

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        input  br_wr_done, br_rd_valid, br_rdata,
        output req_grant, req_done, req_err, req_rdata, busy,
        output UnUb_wr_sel, UnUb_initAddr, UnUb_initAddrEn,
        output UcUb_data_out, UbUc_data_out_en
    );

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        output br_wr_done, br_rd_valid, br_rdata,
        input  req_grant, req_done, req_err, req_rdata, busy,
        input  UnUb_wr_sel, UnUb_initAddr, UnUb_initAddrEn,
        input  UcUb_data_out, UbUc_data_out_en
    );

endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin picker: searches the request vector starting
// at the requester after last_i and returns the first hit.
module uart_rr_arbiter #(
    parameter  int NREQ  = 2,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDX_W'((int'(last_i) + k) % NREQ);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/uart_bridge_arb.sv
// Round-robin arbiter serialising requester transactions onto the UART bridge.
// Define UART_ARB_TIMEOUT_EN to bound the WAIT state by TIMEOUT cycles.
module uart_bridge_arb
    import uart_bridge_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_bridge_arb_if.slave  bus
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e        state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [NREQ-1:0]   arbGrant;
    logic [IDX_W-1:0]  arbIdx;

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
`endif

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_out_of_range
    end

    uart_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i   (bus.req_valid),
        .last_i  (last_q),
        .grant_o (arbGrant),
        .idx_o   (arbIdx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            last_q  <= IDX_W'(NREQ - 1);
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|bus.req_valid) begin
                    grant_d = arbGrant;
                    idx_d   = arbIdx;
                    addr_d  = bus.req_addr[arbIdx*ADDR_W +: ADDR_W];
                    wdata_d = bus.req_wdata[arbIdx*DATA_W +: DATA_W];
                    wr_d    = bus.req_wr[arbIdx];
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_ISSUE;
            ST_ISSUE: begin
`ifdef UART_ARB_TIMEOUT_EN
                cnt_d   = '0;
                err_d   = 1'b0;
`endif
                state_d = ST_WAIT;
            end
            // Only the completion matching the command type ends the wait.
            ST_WAIT: begin
                if (wr_q && bus.br_wr_done) begin
                    state_d = ST_DONE;
                end else if (!wr_q && bus.br_rd_valid) begin
                    rdata_d = bus.br_rdata;
                    state_d = ST_DONE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_q + 8'd1 == TIMEOUT_LIM) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            ST_DONE: begin
                last_d  = idx_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.busy             = (state_q != ST_IDLE);
    assign bus.req_grant        = (state_q != ST_IDLE) ? grant_q : '0;
    assign bus.req_done         = (state_q == ST_DONE) ? grant_q : '0;
    assign bus.req_rdata        = rdata_q;
    assign bus.UnUb_wr_sel      = (state_q == ST_ISSUE) ? (wr_q ? WR_SEL_WRITE : WR_SEL_READ)
                                                        : WR_SEL_NONE;
    assign bus.UnUb_initAddrEn  = (state_q == ST_LOAD);
    assign bus.UnUb_initAddr    = (state_q == ST_LOAD) ? addr_q : '0;
    assign bus.UbUc_data_out_en = (state_q == ST_LOAD) && wr_q;
    assign bus.UcUb_data_out    = ((state_q == ST_LOAD) && wr_q) ? wdata_q : '0;
`ifdef UART_ARB_TIMEOUT_EN
    assign bus.req_err          = (state_q == ST_DONE) && err_q;
`else
    assign bus.req_err          = 1'b0;
`endif

endmodule
